// File: rtl/des_key_schedule_decrypt.sv
// DES decrypt-order key schedule: presents K16..K1 one per handshake by rotating
// the PC-1 halves right, with a valid/ready output and a one-cycle done pulse.
module des_key_schedule_decrypt (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    // Tables use DES bit numbering (1 = MSB); key[64-n] holds DES key bit n.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_reg;
    logic [27:0] c_reg;
    logic [27:0] d_reg;
    logic [3:0]  round_idx_reg;
    logic        subkey_valid_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [55:0] pc1_key;
    logic [55:0] cd;
    logic        shift_one;
    logic        unused_parity;

    assign unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

    genvar gi;
    generate
        for (gi = 0; gi < 56; gi++) begin : g_pc1
            localparam int SRC = 64 - PC1[gi];
            assign pc1_key[55-gi] = key[SRC];
        end
        for (gi = 0; gi < 48; gi++) begin : g_pc2
            localparam int SRC = 56 - PC2[gi];
            assign subkey[47-gi] = cd[SRC];
        end
    endgenerate

    assign cd = {c_reg, d_reg};

    // Next round is 1, 8 or 15: those take a single-position rotate.
    assign shift_one = (round_idx_reg == 4'd0) || (round_idx_reg == 4'd7) ||
                       (round_idx_reg == 4'd14);

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic one);
        return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            c_reg            <= '0;
            d_reg            <= '0;
            round_idx_reg    <= '0;
            subkey_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        c_reg            <= pc1_key[55:28];
                        d_reg            <= pc1_key[27:0];
                        round_idx_reg    <= '0;
                        subkey_valid_reg <= 1'b1;
                        busy_reg         <= 1'b1;
                        state_reg        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (subkey_ready) begin
                        if (round_idx_reg == 4'd15) begin
                            subkey_valid_reg <= 1'b0;
                            done_reg         <= 1'b1;
                            state_reg        <= DONE;
                        end else begin
                            c_reg         <= rotr(c_reg, shift_one);
                            d_reg         <= rotr(d_reg, shift_one);
                            round_idx_reg <= round_idx_reg + 4'd1;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    subkey_valid_reg <= 1'b0;
                    busy_reg         <= 1'b0;
                    done_reg         <= 1'b0;
                    state_reg        <= IDLE;
                end
            endcase
        end
    end

    assign subkey_valid = subkey_valid_reg;
    assign round_idx    = round_idx_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
endmodule

// File: tb/tb_des_key_schedule_decrypt.sv
// Scoreboard bench for des_key_schedule_decrypt: an encrypt-order reference model
// supplies K16..K1, checked against each handshake plus published DES vectors.
module tb_des_key_schedule_decrypt;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] key;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [47:0] exp_q [$];
    logic [3:0]  idx_q [$];
    logic [47:0] enc_k [1:16];
    logic [47:0] run_k [16];
    logic [47:0] ref_k [16];

    int pc1_t [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int pc2_t [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int shifts_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_schedule_decrypt dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key          (key),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Standard encrypt-direction schedule: left rotations, K1..K16.
    task automatic build_enc(input logic [63:0] k);
        logic [55:0] cdv;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] ks;
        for (int j = 0; j < 56; j++) cdv[55-j] = k[64-pc1_t[j]];
        c = cdv[55:28];
        d = cdv[27:0];
        for (int r = 1; r <= 16; r++) begin
            for (int s = 0; s < shifts_t[r-1]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cdv = {c, d};
            for (int j = 0; j < 48; j++) ks[47-j] = cdv[56-pc2_t[j]];
            enc_k[r] = ks;
        end
    endtask

    task automatic run_sched(input logic [63:0] k, input bit stall, input int start_rnd,
                             input logic [63:0] k2, input int rst_rnd, input bit start_on_done);
        int          cyc;
        int          hs;
        int          dones;
        bit          fired;
        bit          pv;
        bit          pr;
        logic [47:0] pk;
        logic [3:0]  pi;
        build_enc(k);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(enc_k[16-i]);
            idx_q.push_back(4'(i));
        end
        @(negedge clk);
        key   = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key   = ~k;
        cyc = 1; hs = 0; dones = 0; fired = 0; pv = 0; pr = 0; pk = '0; pi = '0;
        while (cyc < 400) begin
            start = 1'b0;
            if (pv && !pr) begin
                check_val("stall_valid", 64'(subkey_valid), 64'd1);
                check_val("stall_subkey", 64'(subkey), 64'(pk));
                check_val("stall_idx", 64'(round_idx), 64'(pi));
            end
            check_val("busy_run", 64'(busy), 64'd1);
            if (done) begin
                dones++;
                check_val("done_valid", 64'(subkey_valid), 64'd0);
                check_val("done_hs", 64'(hs), 64'd16);
                if (!stall) check_val("done_cycle", 64'(cyc), 64'd17);
                if (start_on_done) start = 1'b1;
                break;
            end
            if (subkey_valid) begin
                if (idx_q.size() == 0) begin
                    check_val("extra_subkey", 64'(round_idx), 64'hFFFF);
                    break;
                end
                check_val("round_idx", 64'(round_idx), 64'(idx_q[0]));
                check_val("subkey", 64'(subkey), 64'(exp_q[0]));
                if (start_rnd >= 0 && int'(round_idx) == start_rnd && !fired) begin
                    key   = k2;
                    start = 1'b1;
                    fired = 1;
                end
                if (rst_rnd >= 0 && int'(round_idx) == rst_rnd) begin
                    rst = 1'b1;
                    #1;
                    check_val("rst_subkey", 64'(subkey), 64'd0);
                    check_val("rst_valid", 64'(subkey_valid), 64'd0);
                    check_val("rst_idx", 64'(round_idx), 64'd0);
                    check_val("rst_busy", 64'(busy), 64'd0);
                    check_val("rst_done", 64'(done), 64'd0);
                    exp_q.delete();
                    idx_q.delete();
                    @(negedge clk);
                    rst = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        check_val("post_rst_done", 64'(done), 64'd0);
                        check_val("post_rst_busy", 64'(busy), 64'd0);
                    end
                    $display("sched key=%016h aborted by reset at round %0d", k, rst_rnd);
                    return;
                end
                subkey_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (subkey_ready) begin
                    run_k[round_idx] = subkey;
                    void'(exp_q.pop_front());
                    void'(idx_q.pop_front());
                    hs++;
                    $display("hs key=%016h round=%0d subkey=%012h", k, round_idx, subkey);
                end
            end else begin
                check_val("issue_valid", 64'(subkey_valid), 64'd1);
            end
            pv = subkey_valid;
            pr = subkey_ready;
            pk = subkey;
            pi = round_idx;
            @(negedge clk);
            cyc++;
        end
        check_val("done_seen", 64'(dones), 64'd1);
        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        idx_q.delete();
        @(negedge clk);
        start = 1'b0;
        check_val("idle_busy", 64'(busy), 64'd0);
        check_val("idle_done", 64'(done), 64'd0);
        check_val("idle_valid", 64'(subkey_valid), 64'd0);
        @(negedge clk);
        check_val("idle_busy2", 64'(busy), 64'd0);
        check_val("idle_valid2", 64'(subkey_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        key = '0;
        subkey_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_valid", 64'(subkey_valid), 64'd0);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_done", 64'(done), 64'd0);
        check_val("reset_idx", 64'(round_idx), 64'd0);
        check_val("reset_subkey", 64'(subkey), 64'd0);
        rst = 1'b0;

        run_sched(64'h133457799BBCDFF1, 0, -1, 64'h0, -1, 0);
        check_val("std_r0", 64'(run_k[0]), 64'hCB3D8B0E17F5);
        check_val("std_r1", 64'(run_k[1]), 64'hBF918D3D3F0A);
        check_val("std_r15", 64'(run_k[15]), 64'h1B02EFFC7072);
        ref_k = run_k;

        run_sched(64'h0101010101010101, 0, -1, 64'h0, -1, 0);
        for (int i = 0; i < 16; i++) check_val("parity_zero", 64'(run_k[i]), 64'd0);
        run_sched(64'h0000000000000000, 0, -1, 64'h0, -1, 0);
        for (int i = 0; i < 16; i++) check_val("zero_key", 64'(run_k[i]), 64'd0);

        run_sched(64'h133457799BBCDFF1, 1, -1, 64'h0, -1, 0);
        for (int i = 0; i < 16; i++) check_val("stall_seq", 64'(run_k[i]), 64'(ref_k[i]));

        run_sched(64'h133457799BBCDFF1, 0, 5, 64'h0E329232EA6D0D73, -1, 1);
        for (int i = 0; i < 16; i++) check_val("busy_start_seq", 64'(run_k[i]), 64'(ref_k[i]));

        run_sched(64'h133457799BBCDFF1, 0, -1, 64'h0, 8, 0);
        run_sched(64'h133457799BBCDFF1, 0, -1, 64'h0, -1, 0);
        for (int i = 0; i < 16; i++) check_val("fresh_seq", 64'(run_k[i]), 64'(ref_k[i]));

        run_sched(64'h0E329232EA6D0D73, 0, -1, 64'h0, -1, 0);
        run_sched(64'hAAAAAAAAAAAAAAAA, 1, -1, 64'h0, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/des_key_schedule_decrypt.md
DES_KEY_SCHEDULE_DECRYPT -- requirements
Module: des_key_schedule_decrypt

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-high reset, with ports named clk and rst as elsewhere in the codebase.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: single-cycle request to begin a decrypt key schedule.
REQ-005 The block SHALL have port key, input, 64 bits: DES key; key[63] is DES bit 1; parity bits (DES bits 8,16,...,64) are ignored.
REQ-006 The block SHALL have port subkey_ready, input, 1 bit: consumer accepts the current subkey.
REQ-007 The block SHALL have port subkey, output, 48 bits: current round subkey; subkey[47] is PC-2 output bit 1.
REQ-008 The block SHALL have port subkey_valid, output, 1 bit: subkey and round_idx are valid.
REQ-009 The block SHALL have port round_idx, output, 4 bits: decrypt round 0..15 of the subkey being presented.
REQ-010 The block SHALL have port busy, output, 1 bit: high from the start acceptance edge until done.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after the 16th subkey handshake.

Function
REQ-012 The state machine SHALL have three states: IDLE, ISSUE and DONE.
REQ-013 In IDLE, start=1 at a clock edge SHALL load C,D <= PC-1(key) (28+28 bits), clear round_idx to 0, and move to ISSUE; key is sampled only at that edge.
REQ-014 In ISSUE, subkey_valid SHALL be 1 and subkey SHALL equal PC-2(C,D), combinational from registers only.
REQ-015 The first subkey SHALL be valid on the cycle after the start edge (latency 1 cycle) and SHALL equal encrypt subkey K16.
REQ-016 A handshake occurs at an edge where subkey_valid=1 and subkey_ready=1; subkey and round_idx SHALL be held stable while subkey_valid=1 and subkey_ready=0.
REQ-017 On a handshake with round_idx<15, C and D SHALL each rotate right by R[round_idx+1] and round_idx SHALL increment, where R[0..15] = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-018 The rotate-right rule SHALL make decrypt round i present encrypt subkey K(16-i).
REQ-019 Back-to-back handshakes SHALL be supported, giving one subkey per cycle when subkey_ready is held at 1.
REQ-020 On the handshake with round_idx=15, the block SHALL move to DONE; done=1 and subkey_valid=0 for exactly one cycle, then the block SHALL return to IDLE.
REQ-021 busy SHALL be 1 in ISSUE and DONE and 0 in IDLE.
REQ-022 start SHALL be ignored in ISSUE and DONE; in particular, start coincident with the done cycle SHALL NOT be accepted.
REQ-023 Rotation SHALL be modular within each 28-bit half; no bits SHALL cross between C and D.
REQ-024 subkey_ready SHALL be ignored while subkey_valid=0.

Reset
REQ-025 On assertion of rst, the block SHALL immediately return to IDLE and clear C, D, round_idx, subkey_valid, busy and done to 0; subkey SHALL then read 0.
REQ-026 Reset asserted mid-schedule SHALL abort the schedule with no done pulse; the next start SHALL begin a fresh schedule from round 0.
REQ-027 After reset, the first start SHALL behave identically to any later start.

Verification
REQ-028 Scenario, standard key: key=133457799BBCDFF1, start, subkey_ready=1 -> round 0 subkey CB3D8B0E17F5, round 1 BF918D3D3F0A, round 15 1B02EFFC7072; done exactly 17 cycles after the start edge.
REQ-029 Scenario, parity ignored: key=0101010101010101 -> all 16 subkeys 000000000000, identical to the results for key=0000000000000000.
REQ-030 Scenario, backpressure: subkey_ready toggled pseudo-randomly -> subkey and round_idx are stable while stalled, exactly 16 handshakes occur, done pulses once, and the subkey sequence matches the no-stall run.
REQ-031 Scenario, start while busy: start pulsed in round 5 with a different key -> it is ignored and the schedule completes using the original key.
REQ-032 Scenario, reset mid-run: rst asserted at round 8 -> all outputs are 0 at once with no done pulse; a fresh start then reproduces the REQ-028 sequence.
REQ-033 Scenario, encrypt cross-check: for keys 0E329232EA6D0D73 and AAAAAAAAAAAAAAAA, the decrypt round i subkey equals the encrypt-side subkey K(16-i) from the existing encrypt datapath.
